// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one word fetch in flight,
// and presents the returned instruction to decode through a one-entry output slot.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] instr_q;

  logic        slot_free;
  logic [31:0] redirect_target;

  // Handshake: the slot beat transfers on any edge where if_valid && if_ready, except
  // when a redirect in the same cycle squashes it; a request only goes out if the slot
  // will have room for its response.
  assign slot_free       = !valid_q || if_ready;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req    = (state_q == S_REQ) && slot_free && !redirect_valid && !rst;
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      valid_q  <= 1'b0;
      if_pc_q  <= 32'h0;
      instr_q  <= 32'h0;
    end else if (redirect_valid) begin
      // Redirect beats both the response and the decode handshake.
      pc_q    <= redirect_target;
      valid_q <= 1'b0;
      case (state_q)
        S_WAIT:  state_q <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_q <= imem_rvalid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      if (valid_q && if_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The slot is necessarily empty here: no request issues unless it has room.
          if (imem_rvalid) begin
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            if_pc_q <= req_pc_q;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core: owns the architectural PC register and issues word fetches to instruction memory.
- Holds the returned instruction in a one-entry output slot, with a valid/ready handshake to decode.
- Accepts a redirect (resolved branch/jump target from the next-PC select mux) that squashes in-flight work.
- Supplies pc+4 downstream for link-register and next-PC selection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- redirect_valid  input  1  redirect PC this cycle; squashes slot and outstanding fetch.
- redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address (= pc).
- imem_gnt  input  1  memory accepts request this cycle (only meaningful when imem_req=1).
- imem_rvalid  input  1  response data valid; at most one response per granted request, arrives at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  output slot holds a valid instruction.
- if_ready  input  1  decode accepts the slot this cycle.
- if_pc  output  32  PC of the slot instruction.
- if_instr  output  32  slot instruction.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=S_REQ.
  - if_valid=0, if_pc=0, if_instr=0.
  - imem_req forced 0 while rst=1.
  - rst overrides every other input in the same cycle.
- One outstanding request maximum. States S_REQ, S_WAIT, S_DROP.
- slot_free = !if_valid || if_ready.
- imem_req = (state==S_REQ) && slot_free && !redirect_valid && !rst. imem_addr = pc in all states.
- S_REQ:
  - If imem_req && imem_gnt: pc <= pc+4 (wraps 0xFFFF_FFFC -> 0), go to S_WAIT.
  - Otherwise stay in S_REQ.
- S_WAIT:
  - If imem_rvalid: if_valid<=1, if_instr<=imem_rdata, if_pc<=address of that request; go to S_REQ.
  - The slot is guaranteed empty on arrival, so no overwrite is possible.
  - Fetch-to-if_valid latency is 1 cycle after rvalid.
  - Back-to-back requests are possible: the next request issues in the cycle after the response, given slot_free.
- S_DROP: wait for imem_rvalid, discard the data, then go to S_REQ.
- Handshake: if_valid && if_ready at an edge consumes the slot; if_valid<=0 unless refilled at the same edge. While if_valid=1 && if_ready=0, if_pc, if_instr and if_pc_plus4 are held stable.
- Redirect (redirect_valid=1, rst=0):
  - pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0 (this beat is not consumed even if if_ready=1).
  - From S_REQ: stay in S_REQ. No request is issued this cycle.
  - From S_WAIT without rvalid: go to S_DROP.
  - From S_WAIT with rvalid in the same cycle: drop the data, go to S_REQ.
  - From S_DROP without rvalid: stay in S_DROP, pc updated.
  - From S_DROP with rvalid: go to S_REQ, pc updated.
  - Redirect has priority over the response and over the handshake.
- Register the output slot fields and pc. if_pc_plus4 may be combinational from if_pc.
- if_pc/if_instr retain their last values when if_valid=0 (don't-care for decode).

Test Plan:
- Reset release, memory grants every cycle, rvalid 1 cycle after grant, if_ready=1 -> addresses 0x0,0x4,0x8 in order. if_pc/if_instr match the returned words; if_pc_plus4 = if_pc+4.
- Decode stall: if_ready=0 for 5 cycles with slot full -> imem_req=0 throughout and outputs stable. Raise if_ready -> next request issues the same cycle.
- Redirect while in S_WAIT to 0x1000 -> the late response (instr 0xDEADBEEF) is dropped, if_valid stays 0. The next request address is 0x1000, then the slot fills with pc=0x1000.
- Redirect coincident with rvalid and with if_valid=1 && if_ready=1 -> the response is discarded, the slot is cleared, and the next imem_addr is the target. redirect_pc=0x2003 gives address 0x2000.
- Wrap: pc=0xFFFF_FFFC fetched -> if_pc_plus4=0 and the next imem_addr is 0x0000_0000.
- rst asserted mid-S_WAIT -> the next cycle has if_valid=0, imem_req=0 while rst=1, and pc=RESET_PC. A stray rvalid after reset is ignored because the state is S_REQ.
